acc_unit: RTL and testbench

Parametrised accumulator for the datapath, successor to the 12-bit single-register accumulator. It holds one N-bit working value that can be loaded from the data bus or the ALU, incremented, decremented or cleared in one cycle. It adds a multi-cycle barrel-free shifter, one bit per cycle, with a busy/done handshake. It also produces zero and carry status for the control unit.

---
 rtl/acc_unit.sv | 128 ++++++++++++
 tb/tb_acc_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_unit.sv
// Parametrised datapath accumulator: load, increment/decrement and clear complete
// in one cycle. Shifts move one bit per cycle and report progress on busy/done.
module acc_unit #(
    parameter int N   = 12,
    parameter int SHW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           write_en,
    input  logic [N-1:0]   datain,
    input  logic           alu_to_ac,
    input  logic [N-1:0]   alu_out,
    input  logic           inc_en,
    input  logic           dec_en,
    input  logic           clr_en,
    input  logic           shift_start,
    input  logic           shift_dir,
    input  logic           shift_arith,
    input  logic [SHW-1:0] shift_amt,
    output logic [N-1:0]   dataout,
    output logic           zero,
    output logic           carry,
    output logic           busy,
    output logic           done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [SHW-1:0] N_AMT = SHW'(N);

    state_t         state, state_n;
    logic [N-1:0]   acc, acc_n;
    logic           carry_q, carry_n;
    logic           done_q, done_n;
    logic [SHW-1:0] cnt, cnt_n;
    logic           dir_q, dir_n;
    logic           arith_q, arith_n;
    logic [SHW-1:0] amt_clip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            carry_q <= carry_n;
            done_q  <= done_n;
            cnt     <= cnt_n;
            dir_q   <= dir_n;
            arith_q <= arith_n;
        end
    end

    // Amounts beyond the width behave exactly like a full-width shift.
    assign amt_clip = (shift_amt > N_AMT) ? N_AMT : shift_amt;

    // While shifting, only clr_en can interrupt; all other commands are dropped.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        carry_n = carry_q;
        done_n  = 1'b0;
        cnt_n   = cnt;
        dir_n   = dir_q;
        arith_n = arith_q;

        if (clr_en) begin
            state_n = IDLE;
            acc_n   = '0;
            carry_n = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_en) begin
                        acc_n = datain;
                    end else if (alu_to_ac) begin
                        acc_n = alu_out;
                    end else if (inc_en) begin
                        {carry_n, acc_n} = {1'b0, acc} + {{N{1'b0}}, 1'b1};
                    end else if (dec_en) begin
                        carry_n = (acc == '0);
                        acc_n   = acc - N'(1);
                    end else if (shift_start) begin
                        dir_n   = shift_dir;
                        arith_n = shift_arith;
                        cnt_n   = amt_clip;
                        if (amt_clip == '0) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (dir_q) begin
                        carry_n = acc[0];
                        acc_n   = {(arith_q ? acc[N-1] : 1'b0), acc[N-1:1]};
                    end else begin
                        carry_n = acc[N-1];
                        acc_n   = {acc[N-2:0], 1'b0};
                    end
                    cnt_n = cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        dataout = acc;
        zero    = (acc == '0);
        carry   = carry_q;
        busy    = (state == SHIFT);
        done    = done_q;
    end

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: each step drives one clock edge, then compares
// outputs 1 ns later against hand-computed values.
module tb_acc_unit;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_CLR  = 6'b100000;
    localparam logic [5:0] C_WR   = 6'b010000;
    localparam logic [5:0] C_ALU  = 6'b001000;
    localparam logic [5:0] C_INC  = 6'b000100;
    localparam logic [5:0] C_DEC  = 6'b000010;
    localparam logic [5:0] C_SH   = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en, alu_to_ac, inc_en, dec_en, clr_en, shift_start;
    logic        shift_dir, shift_arith;
    logic [3:0]  shift_amt;
    logic [11:0] datain, alu_out;
    logic [11:0] dataout;
    logic        zero, carry, busy, done;

    int checks = 0;
    int passes = 0;

    acc_unit #(.N(12), .SHW(4)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .datain(datain),
        .alu_to_ac(alu_to_ac), .alu_out(alu_out),
        .inc_en(inc_en), .dec_en(dec_en), .clr_en(clr_en),
        .shift_start(shift_start), .shift_dir(shift_dir),
        .shift_arith(shift_arith), .shift_amt(shift_amt),
        .dataout(dataout), .zero(zero), .carry(carry),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Hold the command for exactly one rising edge, return 1 ns after it.
    task automatic applyStimulus(input logic [5:0] cmd, input logic [11:0] d,
                                 input logic [11:0] a, input logic dir,
                                 input logic arith, input logic [3:0] amt);
        {clr_en, write_en, alu_to_ac, inc_en, dec_en, shift_start} = cmd;
        datain      = d;
        alu_out     = a;
        shift_dir   = dir;
        shift_arith = arith;
        shift_amt   = amt;
        @(posedge clk);
        #1;
        {clr_en, write_en, alu_to_ac, inc_en, dec_en, shift_start} = C_NONE;
    endtask

    task automatic idleStep();
        applyStimulus(C_NONE, 12'h000, 12'h000, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        rst = 1'b1;
        {clr_en, write_en, alu_to_ac, inc_en, dec_en, shift_start} = C_NONE;
        shift_dir = 1'b0; shift_arith = 1'b0; shift_amt = 4'd0;
        datain = '0; alu_out = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_data",  32'(dataout), 0);
        checkOutput("rst_carry", 32'(carry), 0);
        checkOutput("rst_busy",  32'(busy), 0);
        checkOutput("rst_done",  32'(done), 0);
        checkOutput("rst_zero",  32'(zero), 1);

        // Command priority
        applyStimulus(C_WR | C_ALU, 12'd12, 12'd23, 1'b0, 1'b0, 4'd0);
        checkOutput("prio_wr_over_alu", 32'(dataout), 12);
        applyStimulus(C_ALU, 12'd0, 12'd23, 1'b0, 1'b0, 4'd0);
        checkOutput("alu_load", 32'(dataout), 23);
        applyStimulus(C_INC | C_DEC, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("inc_data", 32'(dataout), 24);
        checkOutput("inc_carry", 32'(carry), 0);
        applyStimulus(C_CLR | C_WR, 12'h123, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("prio_clr", 32'(dataout), 0);

        // Wrap in both directions
        applyStimulus(C_WR, 12'hFFF, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_INC, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("wrap_inc_data",  32'(dataout), 0);
        checkOutput("wrap_inc_carry", 32'(carry), 1);
        checkOutput("wrap_inc_zero",  32'(zero), 1);
        applyStimulus(C_DEC, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("wrap_dec_data",  32'(dataout), 'hFFF);
        checkOutput("wrap_dec_carry", 32'(carry), 1);
        checkOutput("wrap_dec_zero",  32'(zero), 0);
        applyStimulus(C_WR, 12'hFFF, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("wr_keeps_carry", 32'(carry), 1);
        applyStimulus(C_DEC, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("dec_data",  32'(dataout), 'hFFE);
        checkOutput("dec_carry", 32'(carry), 0);

        // Left shift by 3 of 0x801
        applyStimulus(C_WR, 12'h801, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b0, 1'b0, 4'd3);
        checkOutput("shl_e0_busy", 32'(busy), 1);
        checkOutput("shl_e0_data", 32'(dataout), 'h801);
        idleStep();
        checkOutput("shl_e1_data",  32'(dataout), 'h002);
        checkOutput("shl_e1_carry", 32'(carry), 1);
        checkOutput("shl_e1_done",  32'(done), 0);
        idleStep();
        checkOutput("shl_e2_data", 32'(dataout), 'h004);
        checkOutput("shl_e2_busy", 32'(busy), 1);
        idleStep();
        checkOutput("shl_e3_data",  32'(dataout), 'h008);
        checkOutput("shl_e3_carry", 32'(carry), 0);
        checkOutput("shl_e3_busy",  32'(busy), 0);
        checkOutput("shl_e3_done",  32'(done), 1);
        idleStep();
        checkOutput("shl_e4_done", 32'(done), 0);

        // Arithmetic right by 2, then a new shift accepted on the done cycle
        applyStimulus(C_WR, 12'h800, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b1, 1'b1, 4'd2);
        idleStep();
        checkOutput("sra_e1_data", 32'(dataout), 'hC00);
        idleStep();
        checkOutput("sra_e2_data",  32'(dataout), 'hE00);
        checkOutput("sra_e2_carry", 32'(carry), 0);
        checkOutput("sra_e2_done",  32'(done), 1);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b1, 1'b0, 4'd1);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_done", 32'(done), 0);
        idleStep();
        checkOutput("srl1_data", 32'(dataout), 'h700);
        checkOutput("srl1_done", 32'(done), 1);

        // Clipped logical right by 15 behaves as 12 shifts
        applyStimulus(C_WR, 12'h801, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b1, 1'b0, 4'd15);
        repeat (11) idleStep();
        checkOutput("clip_e11_data", 32'(dataout), 'h001);
        checkOutput("clip_e11_busy", 32'(busy), 1);
        idleStep();
        checkOutput("clip_e12_data",  32'(dataout), 0);
        checkOutput("clip_e12_carry", 32'(carry), 1);
        checkOutput("clip_e12_done",  32'(done), 1);
        checkOutput("clip_e12_busy",  32'(busy), 0);

        // Clipped arithmetic right fills with the sign
        applyStimulus(C_WR, 12'h800, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b1, 1'b1, 4'd14);
        repeat (12) idleStep();
        checkOutput("clip_sra_data",  32'(dataout), 'hFFF);
        checkOutput("clip_sra_carry", 32'(carry), 1);
        checkOutput("clip_sra_done",  32'(done), 1);

        // Zero amount
        applyStimulus(C_WR, 12'h5A5, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("amt0_done", 32'(done), 1);
        checkOutput("amt0_busy", 32'(busy), 0);
        checkOutput("amt0_data", 32'(dataout), 'h5A5);
        idleStep();
        checkOutput("amt0_done_fall", 32'(done), 0);
        checkOutput("amt0_busy_after", 32'(busy), 0);

        // Commands ignored while busy, then clr_en aborts the shift
        applyStimulus(C_WR, 12'h0F0, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b0, 1'b0, 4'd8);
        idleStep();
        checkOutput("abort_e1_data", 32'(dataout), 'h1E0);
        applyStimulus(C_INC, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("abort_inc_ignored", 32'(dataout), 'h3C0);
        applyStimulus(C_WR | C_SH, 12'h111, 12'd0, 1'b0, 1'b0, 4'd1);
        checkOutput("abort_wr_ignored", 32'(dataout), 'h780);
        applyStimulus(C_CLR, 12'd0, 12'd0, 1'b0, 1'b0, 4'd0);
        checkOutput("abort_data",  32'(dataout), 0);
        checkOutput("abort_busy",  32'(busy), 0);
        checkOutput("abort_carry", 32'(carry), 0);
        checkOutput("abort_done",  32'(done), 0);
        idleStep();
        checkOutput("abort_no_done", 32'(done), 0);

        // Asynchronous reset mid-shift
        applyStimulus(C_WR, 12'hABC, 12'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(C_SH, 12'd0, 12'd0, 1'b1, 1'b0, 4'd5);
        checkOutput("pre_rst_busy", 32'(busy), 1);
        checkOutput("pre_rst_data", 32'(dataout), 'hABC);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_data",  32'(dataout), 0);
        checkOutput("async_rst_carry", 32'(carry), 0);
        checkOutput("async_rst_busy",  32'(busy), 0);
        checkOutput("async_rst_done",  32'(done), 0);
        checkOutput("async_rst_zero",  32'(zero), 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_data", 32'(dataout), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
